vsq_dequant_reader: RTL



---
 rtl/vsq_dequant_reader_pkg.sv | 36 +++
 rtl/vsq_dequant_reader_fifo.sv | 109 ++++++++++
 rtl/vsq_dequant_reader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vsq_dequant_reader_pkg.sv
// -----------------------------------------------------------------------------
// vsq_dequant_reader_pkg
// Shared geometry, state encoding and the per-lane dequant helper used by the
// activation read-back path (vsq_dequant_reader and its skid FIFO).
// -----------------------------------------------------------------------------
package vsq_dequant_reader_pkg;

    localparam int DEPTH   = 64;               // RAM words per pass
    localparam int LANES   = 16;               // elements per word
    localparam int Q_W     = 4;                // signed quantized element
    localparam int SF_W    = 18;               // unsigned scale factor
    localparam int OUT_W   = 24;               // signed dequantized element
    localparam int ADDR_W  = 6;                // log2(DEPTH)
    localparam int BEAT_W  = OUT_W * LANES;    // one output beat
    localparam int ENTRY_W = BEAT_W + 1;       // beat plus its last flag

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Signed INT4 times unsigned scale. The true product spans 22 signed bits,
    // so evaluating it directly at OUT_W yields the sign-extended result.
    function automatic logic [OUT_W-1:0] dequant_lane(input logic [Q_W-1:0]  q,
                                                      input logic [SF_W-1:0] sf);
        logic signed [OUT_W-1:0] q_ext_s;
        logic signed [OUT_W-1:0] sf_ext_s;
        q_ext_s  = {{(OUT_W - Q_W){q[Q_W-1]}}, q};
        sf_ext_s = {{(OUT_W - SF_W){1'b0}}, sf};
        return q_ext_s * sf_ext_s;
    endfunction

endpackage

// File: rtl/vsq_dequant_reader_fifo.sv
// -----------------------------------------------------------------------------
// vsq_skid_fifo
// Two-entry registered FIFO. The head entry is a register that drives dout
// directly, so consumers see no combinational path from pop to dout. When the
// FIFO empties the head is cleared, keeping dout at zero while nothing is held.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   push, din    write strobe and entry
//   pop          remove head (only meaningful when not empty)
//   dout         head entry
//   count        occupancy 0..2
//   full, empty  occupancy flags
// -----------------------------------------------------------------------------
module vsq_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [1:0]       count_r;

    // Shift-style storage: head always holds the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push) begin
                        head_r  <= din;
                        count_r <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_r <= din;
                    end else if (push) begin
                        tail_r  <= din;
                        count_r <= 2'd2;
                    end else if (pop) begin
                        head_r  <= '0;
                        count_r <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_r <= tail_r;
                        if (push) begin
                            tail_r <= din;
                        end else begin
                            count_r <= 2'd1;
                        end
                    end
                end
                default: begin
                    head_r  <= '0;
                    count_r <= 2'd0;
                end
            endcase
        end
    end

    assign dout  = head_r;
    assign count = count_r;
    assign full  = (count_r == 2'd2);
    assign empty = (count_r == 2'd0);

    vsq_skid_fifo_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .full  (full)
    );

endmodule

// -----------------------------------------------------------------------------
// vsq_skid_fifo_chk
// Flags a push into a full FIFO that is not popped in the same cycle.
// -----------------------------------------------------------------------------
module vsq_skid_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic full
);

    // Overflow would silently drop a beat.
    always @(posedge clk) begin
        if (rst_n) begin
            a_no_overflow: assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/vsq_dequant_reader.sv
// -----------------------------------------------------------------------------
// vsq_dequant_reader
// Streams DEPTH packed INT4xLANES words out of activation RAM, scales each
// element by its lane's scale factor and presents LANES x OUT_W signed
// activations per beat on a valid/ready interface.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_start                   start a pass (accepted only when idle)
//   i_sf_valid, i_sf_data     load pending scale-factor vector
//   o_ram_re, o_ram_addr      RAM read request
//   i_ram_data                RAM read data, one cycle after o_ram_re
//   o_data, o_valid, i_ready  output beat handshake
//   o_last                    marks beat DEPTH-1
//   o_busy, o_done            pass in progress / pass completed pulse
// -----------------------------------------------------------------------------
module vsq_dequant_reader
    import vsq_dequant_reader_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_sf_valid,
    input  logic [SF_W*LANES-1:0]   i_sf_data,
    output logic                    o_ram_re,
    output logic [ADDR_W-1:0]       o_ram_addr,
    input  logic [Q_W*LANES-1:0]    i_ram_data,
    output logic [OUT_W*LANES-1:0]  o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_last,
    output logic                    o_busy,
    output logic                    o_done
);

    state_e                  state_r;
    state_e                  state_s;
    logic [ADDR_W-1:0]       addr_r;
    logic                    inflight_r;
    logic                    inflight_last_r;
    logic [SF_W*LANES-1:0]   sf_pend_r;
    logic [SF_W*LANES-1:0]   sf_act_r;
    logic                    busy_r;
    logic                    done_r;

    logic                    start_acc_s;
    logic                    re_s;
    logic                    pop_s;
    logic                    last_acc_s;
    logic                    issue_room_s;
    logic [BEAT_W-1:0]       dq_data_s;
    logic [ENTRY_W-1:0]      fifo_din_s;
    logic [ENTRY_W-1:0]      fifo_dout_s;
    logic [1:0]              fifo_count_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;

    assign start_acc_s = i_start && (state_r == ST_IDLE);
    assign pop_s       = !fifo_empty_s && i_ready;
    assign last_acc_s  = pop_s && fifo_dout_s[BEAT_W] && (state_r == ST_DRAIN);

    // Occupancy plus the read in flight must leave room for the new word;
    // a pop in this cycle frees one slot. Written as a sum compare to stay
    // non-negative.
    assign issue_room_s = ({1'b0, fifo_count_s} + {2'b00, inflight_r}) <
                          (3'd2 + {2'b00, pop_s});

    // Next-state and read-issue decode.
    always_comb begin
        state_s = state_r;
        re_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_room_s) begin
                    re_s = 1'b1;
                end else begin
                    re_s = 1'b0;
                end
                if (re_s && (addr_r == LAST_ADDR)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (last_acc_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                re_s    = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Linear read address; parks on the final address until the next start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_r <= '0;
        end else if (start_acc_s) begin
            addr_r <= '0;
        end else if (re_s && (addr_r != LAST_ADDR)) begin
            addr_r <= addr_r + ADDR_W'(1);
        end
    end

    // Track the read whose data arrives next cycle and whether it is the last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            inflight_r      <= re_s;
            inflight_last_r <= re_s && (addr_r == LAST_ADDR);
        end
    end

    // Double-buffered scale factors; a same-cycle load bypasses into active.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sf_pend_r <= '0;
            sf_act_r  <= '0;
        end else begin
            if (i_sf_valid) begin
                sf_pend_r <= i_sf_data;
            end
            if (start_acc_s) begin
                sf_act_r <= i_sf_valid ? i_sf_data : sf_pend_r;
            end
        end
    end

    // Busy and done flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (start_acc_s) begin
                busy_r <= 1'b1;
            end else if (last_acc_s) begin
                busy_r <= 1'b0;
            end
            done_r <= last_acc_s;
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign dq_data_s[g*OUT_W +: OUT_W] =
                dequant_lane(i_ram_data[g*Q_W +: Q_W], sf_act_r[g*SF_W +: SF_W]);
        end
    endgenerate

    assign fifo_din_s = {inflight_last_r, dq_data_s};

    vsq_skid_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (inflight_r),
        .din   (fifo_din_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign o_ram_re   = re_s;
    assign o_ram_addr = addr_r;
    assign o_data     = fifo_dout_s[BEAT_W-1:0];
    assign o_last     = fifo_dout_s[BEAT_W];
    assign o_valid    = !fifo_empty_s;
    assign o_busy     = busy_r;
    assign o_done     = done_r;

endmodule
